// File: rtl/xbar_alloc.sv
// Per-output round-robin crossbar allocator with combinational one-hot grants.
// Define XBAR_ALLOC_PKT_LOCK_EN to hold an output for a multi-beat packet until its last beat.
module xbar_alloc #(
  parameter int INPUT_NUM  = 16,
  parameter int OUTPUT_NUM = 16,
  localparam int DST_W     = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INPUT_NUM-1:0]  req_valid,
  input  logic [DST_W-1:0]      req_dst [0:INPUT_NUM-1],
  input  logic [INPUT_NUM-1:0]  req_last,
  output logic [INPUT_NUM-1:0]  req_ready,
  input  logic [OUTPUT_NUM-1:0] out_ready,
  output logic [OUTPUT_NUM-1:0] out_valid,
  output logic [INPUT_NUM-1:0]  xbar_sel [0:OUTPUT_NUM-1],
  output logic [OUTPUT_NUM-1:0] out_locked
);

  localparam int IDX_W = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;

  logic [IDX_W-1:0]      ptr  [0:OUTPUT_NUM-1];
  logic [IDX_W-1:0]      win  [0:OUTPUT_NUM-1];
  logic [INPUT_NUM-1:0]  cand [0:OUTPUT_NUM-1];
  logic [OUTPUT_NUM-1:0] xfer;

`ifdef XBAR_ALLOC_PKT_LOCK_EN
  logic [IDX_W-1:0]      owner [0:OUTPUT_NUM-1];
  logic [OUTPUT_NUM-1:0] locked;
  assign out_locked = locked;
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign out_locked  = '0;
`endif

  // (base + k) mod INPUT_NUM for k in [0, INPUT_NUM)
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= INPUT_NUM) s = s - INPUT_NUM;
    return IDX_W'(s);
  endfunction

  always_comb begin
    for (int j = 0; j < OUTPUT_NUM; j++) begin
      for (int i = 0; i < INPUT_NUM; i++) begin
        cand[j][i] = req_valid[i] && (req_dst[i] == DST_W'(j));
      end
    end
  end

  // Descending scan so the candidate closest to ptr is written last and wins.
  always_comb begin
    for (int j = 0; j < OUTPUT_NUM; j++) begin
      xbar_sel[j] = '0;
      win[j]      = '0;
      for (int k = INPUT_NUM-1; k >= 0; k--) begin
        if (cand[j][wrap_idx(ptr[j], k)]) begin
          win[j] = wrap_idx(ptr[j], k);
        end
      end
`ifdef XBAR_ALLOC_PKT_LOCK_EN
      if (locked[j]) begin
        win[j] = owner[j];
      end
`endif
      xbar_sel[j][win[j]] = cand[j][win[j]];
      out_valid[j]        = |xbar_sel[j];
      xfer[j]             = out_valid[j] && out_ready[j];
    end
  end

  always_comb begin
    req_ready = '0;
    for (int j = 0; j < OUTPUT_NUM; j++) begin
      req_ready = req_ready | (xbar_sel[j] & {INPUT_NUM{out_ready[j]}});
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < OUTPUT_NUM; j++) begin
        ptr[j] <= '0;
`ifdef XBAR_ALLOC_PKT_LOCK_EN
        owner[j]  <= '0;
        locked[j] <= 1'b0;
`endif
      end
    end else begin
      for (int j = 0; j < OUTPUT_NUM; j++) begin
        if (xfer[j]) begin
`ifdef XBAR_ALLOC_PKT_LOCK_EN
          if (!req_last[win[j]]) begin
            owner[j]  <= win[j];
            locked[j] <= 1'b1;
          end else begin
            ptr[j]    <= wrap_idx(win[j], 1);
            locked[j] <= 1'b0;
          end
`else
          ptr[j] <= wrap_idx(win[j], 1);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_xbar_alloc.sv
// Bench for xbar_alloc (4x4): directed scenarios plus random traffic against a reference model.
// Honours XBAR_ALLOC_PKT_LOCK_EN the same way the design does.
module tb_xbar_alloc;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req_valid, req_last, req_ready, out_ready, out_valid, out_locked;
  logic [1:0] req_dst  [0:3];
  logic [3:0] xbar_sel [0:3];

  int n_asserts = 0;
  int n_fail    = 0;

  int         m_ptr    [4];
  int         m_owner  [4];
  bit         m_locked [4];
  logic [3:0] exp_sel  [4];
  logic [3:0] exp_ready;

  logic [3:0] rr_tab [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`ifdef XBAR_ALLOC_PKT_LOCK_EN
  logic [3:0] pk_win [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000};
  logic       pk_lk  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
  logic [3:0] pk_win [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
  logic       pk_lk  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

  xbar_alloc #(.INPUT_NUM(4), .OUTPUT_NUM(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_dst   (req_dst),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .xbar_sel  (xbar_sel),
    .out_locked(out_locked)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: locked output serves only its owner; otherwise first requester at or after ptr.
  function automatic void model_comb();
    int i;
    for (int j = 0; j < 4; j++) begin
      exp_sel[j] = 4'b0000;
      if (m_locked[j]) begin
        if (req_valid[m_owner[j]] && req_dst[m_owner[j]] == j) exp_sel[j][m_owner[j]] = 1'b1;
      end else begin
        for (int k = 0; k < 4; k++) begin
          i = (m_ptr[j] + k) % 4;
          if (exp_sel[j] == 4'b0000 && req_valid[i] && req_dst[i] == j) exp_sel[j][i] = 1'b1;
        end
      end
    end
    for (int r = 0; r < 4; r++) begin
      exp_ready[r] = exp_sel[req_dst[r]][r] && out_ready[req_dst[r]];
    end
  endfunction

  function automatic void model_next();
    int w;
    if (reset) begin
      for (int j = 0; j < 4; j++) begin
        m_ptr[j] = 0; m_owner[j] = 0; m_locked[j] = 1'b0;
      end
      return;
    end
    for (int j = 0; j < 4; j++) begin
      if (exp_sel[j] != 4'b0000 && out_ready[j]) begin
        w = $clog2(exp_sel[j]);
`ifdef XBAR_ALLOC_PKT_LOCK_EN
        if (!req_last[w]) begin
          m_locked[j] = 1'b1;
          m_owner[j]  = w;
        end else begin
          m_locked[j] = 1'b0;
          m_ptr[j]    = (w + 1) % 4;
        end
`else
        m_ptr[j] = (w + 1) % 4;
`endif
      end
    end
  endfunction

  task automatic settle_check(input string tag);
    logic [15:0] gs, es;
    logic [3:0]  ev, el;
    #2;
    model_comb();
    for (int j = 0; j < 4; j++) begin
      gs[j*4 +: 4] = xbar_sel[j];
      es[j*4 +: 4] = exp_sel[j];
      ev[j]        = |exp_sel[j];
      el[j]        = m_locked[j];
    end
    chk({tag, ".sel"},    32'(gs),         32'(es));
    chk({tag, ".valid"},  32'(out_valid),  32'(ev));
    chk({tag, ".ready"},  32'(req_ready),  32'(exp_ready));
    chk({tag, ".locked"}, 32'(out_locked), 32'(el));
  endtask

  task automatic advance();
    model_next();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 4'b0000;
    settle_check("rst");
    advance();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_last = '0; out_ready = '0;
    for (int i = 0; i < 4; i++) req_dst[i] = 2'd0;
    for (int j = 0; j < 4; j++) begin
      m_ptr[j] = 0; m_owner[j] = 0; m_locked[j] = 1'b0;
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Cleared state with nothing requested
    out_ready = 4'hF;
    settle_check("idle");
    chk("idle.out_valid", 32'(out_valid), 32'h0);
    chk("idle.req_ready", 32'(req_ready), 32'h0);
    chk("idle.out_locked", 32'(out_locked), 32'h0);
    advance();

    // All four requesters to output 2: strict rotation
    req_valid = 4'hF; req_last = 4'hF;
    for (int i = 0; i < 4; i++) req_dst[i] = 2'd2;
    for (int c = 0; c < 5; c++) begin
      settle_check("rr");
      chk("rr.sel2", 32'(xbar_sel[2]), 32'(rr_tab[c]));
      advance();
    end

    // Independent outputs granting in the same cycle
    req_valid = 4'b0101; req_dst[0] = 2'd0; req_dst[2] = 2'd3;
    settle_check("indep");
    chk("indep.ready", 32'(req_ready), 32'h5);
    chk("indep.sel0", 32'(xbar_sel[0]), 32'h1);
    chk("indep.sel3", 32'(xbar_sel[3]), 32'h4);
    chk("indep.sel1", 32'(xbar_sel[1]), 32'h0);
    chk("indep.sel2", 32'(xbar_sel[2]), 32'h0);
    advance();

    // Stalled winner keeps its grant and the pointer holds
    do_reset();
    req_valid = 4'b1100; req_dst[2] = 2'd1; req_dst[3] = 2'd1; req_last = 4'hF;
    for (int c = 0; c < 4; c++) begin
      out_ready = (c < 3) ? 4'b1101 : 4'b1111;
      settle_check("stall");
      chk("stall.sel1", 32'(xbar_sel[1]), 32'h4);
      chk("stall.ready2", 32'(req_ready[2]), 32'(c == 3));
      advance();
    end
    settle_check("stall_after");
    chk("stall_after.sel1", 32'(xbar_sel[1]), 32'h8);
    advance();

    // Three-beat packet from input 1 competing with input 3 at output 0
    do_reset();
    out_ready = 4'hF; req_valid = 4'b1010; req_dst[1] = 2'd0; req_dst[3] = 2'd0;
    for (int c = 0; c < 4; c++) begin
      req_last = {1'b1, 1'b0, (c == 2), 1'b0};
      settle_check("pkt");
      chk("pkt.sel0", 32'(xbar_sel[0]), 32'(pk_win[c]));
      chk("pkt.locked0", 32'(out_locked[0]), 32'(pk_lk[c]));
      advance();
    end

    // Reset in the middle of a packet drops the lock
    do_reset();
    req_valid = 4'b0010; req_dst[1] = 2'd0; req_last = 4'b0000;
    settle_check("mid");
    chk("mid.sel0", 32'(xbar_sel[0]), 32'h2);
    advance();
    reset = 1'b1; req_valid = 4'b0011; req_dst[0] = 2'd0;
    settle_check("mid_rst");
    advance();
    reset = 1'b0;
    settle_check("mid_after");
    chk("mid_after.locked", 32'(out_locked), 32'h0);
    chk("mid_after.sel0", 32'(xbar_sel[0]), 32'h1);
    advance();

    // Random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 49) == 0);
      req_valid = 4'($urandom);
      req_last  = 4'($urandom) & 4'($urandom);
      out_ready = 4'($urandom) | 4'($urandom);
      for (int i = 0; i < 4; i++) req_dst[i] = 2'($urandom);
      settle_check("rand");
      advance();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/xbar_alloc.md
XBAR_ALLOC -- requirements
Module: xbar_alloc

Interface
REQ-001 SHALL have parameter INPUT_NUM, default 16, number of requesters (crossbar inputs).
REQ-002 SHALL have parameter OUTPUT_NUM, default 16, number of crossbar outputs.
REQ-003 SHALL derive localparam DST_W = max(1, clog2(OUTPUT_NUM)) as the destination index width.
REQ-004 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, [INPUT_NUM-1:0], requester i presents a beat.
REQ-007 SHALL have port req_dst, input, [DST_W-1:0] [0:INPUT_NUM-1], destination output index per requester.
REQ-008 SHALL have port req_last, input, [INPUT_NUM-1:0], beat is the final beat of its packet.
REQ-009 SHALL have port req_ready, output, [INPUT_NUM-1:0], beat of requester i is accepted this cycle.
REQ-010 SHALL have port out_ready, input, [OUTPUT_NUM-1:0], output j can take a beat.
REQ-011 SHALL have port out_valid, output, [OUTPUT_NUM-1:0], output j carries a granted beat.
REQ-012 SHALL have port xbar_sel, output, [INPUT_NUM-1:0] [0:OUTPUT_NUM-1], one-hot per-output input select, directly drivable into the crossbar select input.
REQ-013 SHALL have port out_locked, output, [OUTPUT_NUM-1:0], output j is held by an in-progress packet.

Function
REQ-014 Candidate set for output j SHALL be {i : req_valid[i] and req_dst[i]==j}; req_dst >= OUTPUT_NUM SHALL match no output and its req_ready SHALL be 0.
REQ-015 Unlocked output j SHALL grant the first candidate found scanning ptr[j], ptr[j]+1, ..., wrapping INPUT_NUM-1 -> 0.
REQ-016 Locked output j SHALL grant only its owner owner[j]; if the owner is not a candidate, xbar_sel[j] SHALL be all-zero and the lock SHALL be kept.
REQ-017 xbar_sel[j] SHALL be one-hot of the winner or all-zero; out_valid[j] SHALL equal OR of xbar_sel[j]; both SHALL be combinational (zero-cycle grant latency).
REQ-018 req_ready[i] SHALL be 1 iff i is the winner at output req_dst[i] and out_ready[req_dst[i]] is 1; a transfer is req_valid & req_ready.
REQ-019 Grant SHALL NOT depend on out_ready; a stalled winner keeps its grant while requests are unchanged and ptr[j] SHALL NOT move.
REQ-020 On a transfer at output j with req_last=1: ptr[j] <= (winner+1) mod INPUT_NUM, lock cleared next cycle.
REQ-021 On a transfer at output j with req_last=0: owner[j] <= winner, out_locked[j] <= 1 next cycle; ptr[j] unchanged.
REQ-022 Outputs SHALL arbitrate independently; all OUTPUT_NUM outputs may transfer in the same cycle.
REQ-023 Each requester has one destination per cycle, so a requester SHALL never be granted at more than one output.

Reset
REQ-024 While reset is high at a clock edge: all ptr[j] <= 0, all locks and owners <= 0, so out_locked = 0 next cycle.
REQ-025 Reset asserted mid-packet SHALL abandon the lock; no other state retained.
REQ-026 Combinational outputs after reset SHALL follow REQ-014..018 from cleared state (xbar_sel, out_valid, req_ready all 0 when req_valid = 0).

Configuration
REQ-027 Macro XBAR_ALLOC_PKT_LOCK_EN defined: multi-beat packet locking per REQ-016, REQ-020, REQ-021.
REQ-028 Macro XBAR_ALLOC_PKT_LOCK_EN undefined: req_last ignored, every transfer treated as last, no lock/owner state, out_locked tied 0.

Verification (bench INPUT_NUM=4, OUTPUT_NUM=4 unless stated)
REQ-029 After reset, req_valid=4'b1111, all req_dst=2, out_ready=all 1, req_last=1 -> grants at output 2 cycle by cycle: 0,1,2,3,0; xbar_sel[2]=0001,0010,0100,1000,0001.
REQ-030 req_valid=4'b0101, req_dst[0]=0, req_dst[2]=3, out_ready=all 1 -> same cycle req_ready=0101, xbar_sel[0]=0001, xbar_sel[3]=0100, others 0.
REQ-031 Lock on: input 1 sends 3 beats (last on beat 3) to output 0 while input 3 also requests output 0 -> input 1 wins all 3 beats, out_locked[0]=1 between, input 3 granted on cycle 4, ptr[0]=2 afterward.
REQ-032 Output 1 winner=input 2, out_ready[1]=0 for 3 cycles then 1 -> xbar_sel[1]=0100 all 4 cycles, req_ready[2]=0 then 1, ptr[1] changes only after cycle 4.
REQ-033 Lock on: reset asserted after beat 1 of a 3-beat packet at output 0 -> next cycle out_locked=0, ptr[0]=0, input 0 wins if requesting.
REQ-034 Macro undefined: repeat REQ-031 stimulus -> inputs 1 and 3 alternate per beat, out_locked stays 0.
